quad_decoder: RTL and testbench

Quadrature decoder that turns two asynchronous encoder phases into single-cycle count-enable and direction strobes. It sits directly upstream of the up/down counter: `step_en` drives the counter's `en` and `step_up` drives its `up_n` (1=up). The block synchronises and glitch-filters both phases, tracks the Gray-code position, and flags illegal double transitions.

---
 rtl/qdec_pkg.sv | 45 ++++
 rtl/qdec_chan_filter.sv | 66 ++++++
 rtl/quad_decoder.sv | 145 ++++++++++++++
 tb/tb_quad_decoder.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qdec_pkg.sv
// -----------------------------------------------------------------------------
// qdec_pkg
// Shared types, constants and helpers for the quadrature decoder.
//   qdec_state_e  : Gray-code position, encoded as the {A,B} phase levels.
//   QDEC_MODE_X*  : legal values of the DECODE_MODE parameter.
//   QDEC_FILT_EN  : 1 when QDEC_GLITCH_FILTER_EN is defined, else 0.
//   qdec_dir()    : classifies a position change as {legal, up}.
// Build option: QDEC_GLITCH_FILTER_EN compiles in the per-phase glitch filter.
// -----------------------------------------------------------------------------
package qdec_pkg;

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S10 = 2'b10,
    S11 = 2'b11,
    S01 = 2'b01
  } qdec_state_e;

  localparam int QDEC_MODE_X1 = 1;
  localparam int QDEC_MODE_X2 = 2;
  localparam int QDEC_MODE_X4 = 4;

`ifdef QDEC_GLITCH_FILTER_EN
  localparam int QDEC_FILT_EN = 1;
`else
  localparam int QDEC_FILT_EN = 0;
`endif

  // Returns {legal, up}. legal = exactly one phase changed. up = next is the
  // successor of prev in the up sequence S00->S10->S11->S01->S00.
  function automatic logic [1:0] qdec_dir(input qdec_state_e prev,
                                          input qdec_state_e next);
    logic [1:0]  diff;
    qdec_state_e succ;
    diff = prev ^ next;
    case (prev)
      S00:     succ = S10;
      S10:     succ = S11;
      S11:     succ = S01;
      default: succ = S00;
    endcase
    return {(diff == 2'b01) || (diff == 2'b10), next == succ};
  endfunction

endpackage

// File: rtl/qdec_chan_filter.sv
// -----------------------------------------------------------------------------
// qdec_chan_filter
// One encoder phase: a SYNC_STAGES-deep synchroniser followed (when
// QDEC_GLITCH_FILTER_EN is defined) by a stability filter that accepts a new
// level only after it has differed from the accepted level for FILT_CYCLES
// consecutive cycles. Without the macro the synchronised level is passed on.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   raw        : asynchronous phase input
//   level      : accepted (synchronised, filtered) level, registered
// Build option: QDEC_GLITCH_FILTER_EN.
// -----------------------------------------------------------------------------
module qdec_chan_filter #(
  parameter int SYNC_STAGES = 2
`ifdef QDEC_GLITCH_FILTER_EN
  ,
  parameter int FILT_CYCLES = 4
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef QDEC_GLITCH_FILTER_EN
  localparam int CNT_W = $clog2(FILT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             acc_q;

  // cnt holds the number of differing cycles already seen; the level is taken
  // on the cycle that would bring it to FILT_CYCLES, and cnt clears then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      acc_q <= 1'b0;
    end else if (sync_lvl == acc_q) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(FILT_CYCLES - 1)) begin
      acc_q <= sync_lvl;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign level = acc_q;
`else
  assign level = sync_lvl;
`endif

endmodule

// File: rtl/quad_decoder.sv
// -----------------------------------------------------------------------------
// quad_decoder
// Turns two asynchronous quadrature phases into single-cycle count strobes
// for a downstream up/down counter, and flags illegal double transitions.
// Parameters: SYNC_STAGES (2..4), FILT_CYCLES (1..255), DECODE_MODE (1/2/4),
//             ERR_CNT_W (error counter width).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   enc_a/b    : asynchronous encoder phases
//   err_clr    : synchronous clear of err_cnt (wins over an increment)
//   step_en    : one-cycle count strobe
//   step_up    : direction of the strobe (1=up), held between strobes
//   err        : one-cycle strobe on an illegal transition
//   err_cnt    : saturating count of illegal transitions
//   ab_state   : accepted {A,B} position (state register of the decoder)
// Handshake: none. step_en/step_up and err are plain strobes valid for the
// single cycle they are high; the consumer samples them every cycle and there
// is no ready/backpressure path.
// Build option: QDEC_GLITCH_FILTER_EN enables the per-phase glitch filter.
// -----------------------------------------------------------------------------
module quad_decoder
  import qdec_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int DECODE_MODE = 4,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enc_a,
  input  logic                 enc_b,
  input  logic                 err_clr,
  output logic                 step_en,
  output logic                 step_up,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [1:0]           ab_state
);

  // Edges it takes a level held through reset to reach the accepted level.
  localparam int PRIME_LEN = SYNC_STAGES + QDEC_FILT_EN * FILT_CYCLES;
  localparam int PRIME_W   = $clog2(PRIME_LEN + 2);

  logic               lvl_a;
  logic               lvl_b;
  qdec_state_e        state;
  qdec_state_e        nxt_state;
  logic [PRIME_W-1:0] prime_cnt;
  logic               prime;
  logic [1:0]         dir;
  logic               changed;
  logic               legal;
  logic               a_changed;
  logic               count_ok;

  qdec_chan_filter #(
    .SYNC_STAGES (SYNC_STAGES)
`ifdef QDEC_GLITCH_FILTER_EN
    ,
    .FILT_CYCLES (FILT_CYCLES)
`endif
  ) u_filt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (enc_a),
    .level (lvl_a)
  );

  qdec_chan_filter #(
    .SYNC_STAGES (SYNC_STAGES)
`ifdef QDEC_GLITCH_FILTER_EN
    ,
    .FILT_CYCLES (FILT_CYCLES)
`endif
  ) u_filt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (enc_b),
    .level (lvl_b)
  );

  assign nxt_state = qdec_state_e'({lvl_a, lvl_b});

  // The accepted level settles on edge PRIME_LEN, so the prime phase loads
  // ab_state through edge PRIME_LEN+1 to capture that settled value before
  // decoding begins.
  assign prime = (prime_cnt != PRIME_W'(PRIME_LEN + 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prime_cnt <= '0;
    end else if (prime) begin
      prime_cnt <= prime_cnt + PRIME_W'(1);
    end
  end

  always_comb begin
    dir       = qdec_dir(state, nxt_state);
    changed   = (nxt_state != state);
    legal     = dir[1];
    a_changed = (nxt_state == S10 || nxt_state == S11) !=
                (state == S10 || state == S11);
    case (DECODE_MODE)
      // x1 counts only the S00<->S10 edge pair, so jitter on it nets zero.
      QDEC_MODE_X1: count_ok = (state == S00 && nxt_state == S10) ||
                               (state == S10 && nxt_state == S00);
      QDEC_MODE_X2: count_ok = a_changed;
      QDEC_MODE_X4: count_ok = 1'b1;
      default:      count_ok = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S00;
      step_en <= 1'b0;
      step_up <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      step_en <= 1'b0;
      err     <= 1'b0;
      if (prime) begin
        state <= nxt_state;
      end else if (changed) begin
        state <= nxt_state;
        if (!legal) begin
          err <= 1'b1;
        end else if (count_ok) begin
          step_en <= 1'b1;
          step_up <= dir[0];
        end
      end
      if (err_clr) begin
        err_cnt <= '0;
      end else if (!prime && changed && !legal && (err_cnt != '1)) begin
        err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
    end
  end

  assign ab_state = state;

endmodule

// File: tb/tb_quad_decoder.sv
// -----------------------------------------------------------------------------
// tb_quad_decoder
// Drives one shared pair of encoder phases into three decoders (x4, x2, x1)
// and scores their strobes against queues filled from a position model.
// -----------------------------------------------------------------------------
module tb_quad_decoder;

`ifdef QDEC_GLITCH_FILTER_EN
  localparam int LAT = 2 + 4 + 1;
`else
  localparam int LAT = 2 + 1;
`endif

  logic       clk;
  logic       rst_n;
  logic       enc_a;
  logic       enc_b;
  logic       err_clr;
  logic [2:0] step_en;
  logic [2:0] step_up;
  logic [2:0] err;
  logic [7:0] err_cnt [3];
  logic [1:0] ab_state [3];

  int n_cmp = 0;
  int n_err = 0;
  int n_step [3];
  int exp_errs = 0;
  logic [1:0] cur_ab;
  string names [3] = '{"x4", "x2", "x1"};

  logic [0:0] exp_q4 [$];
  logic [0:0] exp_q2 [$];
  logic [0:0] exp_q1 [$];
  logic [0:0] err_q [$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  // ---------------- DUTs ----------------
  quad_decoder #(.DECODE_MODE(4)) u_x4 (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .err_clr(err_clr),
    .step_en(step_en[0]), .step_up(step_up[0]), .err(err[0]),
    .err_cnt(err_cnt[0]), .ab_state(ab_state[0])
  );

  quad_decoder #(.DECODE_MODE(2)) u_x2 (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .err_clr(err_clr),
    .step_en(step_en[1]), .step_up(step_up[1]), .err(err[1]),
    .err_cnt(err_cnt[1]), .ab_state(ab_state[1])
  );

  quad_decoder #(.DECODE_MODE(1)) u_x1 (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .err_clr(err_clr),
    .step_en(step_en[2]), .step_up(step_up[2]), .err(err[2]),
    .err_cnt(err_cnt[2]), .ab_state(ab_state[2])
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic int pos(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model(input logic [1:0] p, input logic [1:0] n);
    int   d;
    logic up;
    d = (pos(n) - pos(p) + 4) % 4;
    if (d == 2) begin
      err_q.push_back(1'b1);
      exp_errs++;
    end else if (d != 0) begin
      up = (d == 1);
      exp_q4.push_back(up);
      if (p[1] != n[1]) exp_q2.push_back(up);
      if ((p == 2'b00 && n == 2'b10) || (p == 2'b10 && n == 2'b00))
        exp_q1.push_back(up);
    end
  endtask

  task automatic pop_step(input int i, output bit ok, output logic up);
    ok = 1'b0;
    up = 1'b0;
    case (i)
      0: if (exp_q4.size() > 0) begin ok = 1'b1; up = exp_q4.pop_front(); end
      1: if (exp_q2.size() > 0) begin ok = 1'b1; up = exp_q2.pop_front(); end
      default: if (exp_q1.size() > 0) begin ok = 1'b1; up = exp_q1.pop_front(); end
    endcase
  endtask

  function automatic int sat_errs();
    return (exp_errs > 255) ? 255 : exp_errs;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    bit   ok;
    logic up;
    for (int i = 0; i < 3; i++) begin
      if (step_en[i] === 1'b1) begin
        n_step[i]++;
        pop_step(i, ok, up);
        if (ok) check({"dir_", names[i]}, 32'(step_up[i]), 32'(up));
        else    check({"stray_step_", names[i]}, 1, 0);
      end
    end
    if (err[0] === 1'b1) begin
      if (err_q.size() > 0) begin
        void'(err_q.pop_front());
        check("err_with_step", 32'(step_en[0]), 0);
      end else begin
        check("stray_err", 1, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic move(input logic [1:0] n, input int hold);
    @(negedge clk);
    model(cur_ab, n);
    enc_a  = n[1];
    enc_b  = n[0];
    cur_ab = n;
    repeat (hold) @(negedge clk);
  endtask

  task automatic check_all_errcnt(input string tag);
    for (int i = 0; i < 3; i++)
      check({tag, "_", names[i]}, 32'(err_cnt[i]), 32'(sat_errs()));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   k;
    int   base [3];
    for (int i = 0; i < 3; i++) n_step[i] = 0;
    rst_n   = 1'b0;
    enc_a   = 1'b1;
    enc_b   = 1'b1;
    err_clr = 1'b0;
    cur_ab  = 2'b11;

    // Reset values, with both phases high.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check({"rst_step_en_", names[i]}, 32'(step_en[i]), 0);
      check({"rst_step_up_", names[i]}, 32'(step_up[i]), 0);
      check({"rst_err_", names[i]}, 32'(err[i]), 0);
      check({"rst_err_cnt_", names[i]}, 32'(err_cnt[i]), 0);
      check({"rst_ab_", names[i]}, 32'(ab_state[i]), 0);
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check({"prime_ab_", names[i]}, 32'(ab_state[i]), 32'h3);
      check({"prime_err_cnt_", names[i]}, 32'(err_cnt[i]), 0);
      check({"prime_no_step_", names[i]}, 32'(n_step[i]), 0);
    end

    // Walk to S00 with legal steps.
    move(2'b01, 20);
    move(2'b00, 20);

    // First A edge: measure latency on the x4 decoder.
    for (int i = 0; i < 3; i++) base[i] = n_step[i];
    @(negedge clk);
    model(cur_ab, 2'b10);
    enc_a  = 1'b1;
    cur_ab = 2'b10;
    k = 1;
    while (k <= 20) begin
      @(posedge clk);
      #1;
      if (step_en[0]) break;
      k++;
    end
    check("latency_x4", 32'(k), 32'(LAT));
    repeat (20) @(negedge clk);
    move(2'b11, 20);
    move(2'b01, 20);
    move(2'b00, 20);
    // Seven more full up cycles.
    for (int c = 0; c < 7; c++) begin
      move(2'b10, 20);
      move(2'b11, 20);
      move(2'b01, 20);
      move(2'b00, 20);
    end
    check("up_count_x4", 32'(n_step[0] - base[0]), 32);
    check("up_count_x2", 32'(n_step[1] - base[1]), 16);
    check("up_count_x1", 32'(n_step[2] - base[2]), 8);

    // Two full down cycles.
    for (int c = 0; c < 2; c++) begin
      move(2'b01, 20);
      move(2'b11, 20);
      move(2'b10, 20);
      move(2'b00, 20);
    end

    // x1 jitter on the A edge: alternating up/down, net zero.
    base[2] = n_step[2];
    for (int c = 0; c < 5; c++) begin
      move(2'b10, 20);
      move(2'b00, 20);
    end
    check("jitter_count_x1", 32'(n_step[2] - base[2]), 10);

    // Two-cycle glitch on B.
    @(negedge clk);
`ifndef QDEC_GLITCH_FILTER_EN
    model(2'b00, 2'b01);
    model(2'b01, 2'b00);
`endif
    enc_b = 1'b1;
    repeat (2) @(negedge clk);
    enc_b = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_ab_x4", 32'(ab_state[0]), 0);

    // Illegal double transition S00->S11.
    move(2'b11, 20);
    check_all_errcnt("err_one");
    check("err_one_ab", 32'(ab_state[0]), 32'h3);
    // Toggle up to exactly 255 errors, then past saturation.
    for (int c = 0; c < 254; c++) move(~cur_ab, 10);
    check_all_errcnt("err_255");
    for (int c = 0; c < 46; c++) move(~cur_ab, 10);
    check_all_errcnt("err_sat");

    // err_clr on the same edge as an error increment.
    @(negedge clk);
    model(cur_ab, ~cur_ab);
    enc_a  = ~cur_ab[1];
    enc_b  = ~cur_ab[0];
    cur_ab = ~cur_ab;
    repeat (LAT - 1) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_errs = 0;
    for (int i = 0; i < 3; i++) begin
      check({"clr_err_pulse_", names[i]}, 32'(err[i]), 1);
      check({"clr_err_cnt_", names[i]}, 32'(err_cnt[i]), 0);
    end
    repeat (15) @(negedge clk);

    move(2'b11, 20);
    check_all_errcnt("err_after_clr");

    // Up step, then abort a following edge with reset while it is filtering.
    move(2'b01, 20);
    check("pre_rst_up_x4", 32'(step_up[0]), 1);
    @(negedge clk);
    enc_a = 1'b0;
    enc_b = 1'b0;
`ifdef QDEC_GLITCH_FILTER_EN
    repeat (4) @(negedge clk);
`else
    repeat (1) @(negedge clk);
`endif
    #3;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check({"mid_rst_step_en_", names[i]}, 32'(step_en[i]), 0);
      check({"mid_rst_step_up_", names[i]}, 32'(step_up[i]), 0);
      check({"mid_rst_err_cnt_", names[i]}, 32'(err_cnt[i]), 0);
      check({"mid_rst_ab_", names[i]}, 32'(ab_state[i]), 0);
    end
    exp_errs = 0;
    cur_ab   = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) base[i] = n_step[i];
    repeat (20) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check({"rerun_ab_", names[i]}, 32'(ab_state[i]), 0);
      check({"rerun_no_step_", names[i]}, 32'(n_step[i] - base[i]), 0);
    end

    // Nothing left unmatched.
    check("left_q4", 32'(exp_q4.size()), 0);
    check("left_q2", 32'(exp_q2.size()), 0);
    check("left_q1", 32'(exp_q1.size()), 0);
    check("left_err_q", 32'(err_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
